// File: rtl/hazard_detection_unit_if.sv
// Signal bundle between the decode stage and the hazard detection unit.
// master = pipeline side (drives ID/EX/MEM fields), slave = hazard unit.
interface hazard_detection_unit_if;
    logic [4:0]  RS_ID;
    logic [4:0]  RT_ID;
    logic        UsesRT_ID;
    logic        Branch_ID;
    logic        BranchTaken_ID;
    logic        Jump_ID;
    logic [4:0]  RD_EX;
    logic        RegWrite_EX;
    logic        MemRead_EX;
    logic [4:0]  RD_MEM;
    logic        MemRead_MEM;
    logic        PCWrite;
    logic        IFIDWrite;
    logic        IDEX_Bubble;
    logic        IFID_Flush;
    logic [15:0] StallCount;

    modport master (
        output RS_ID, RT_ID, UsesRT_ID, Branch_ID, BranchTaken_ID, Jump_ID,
               RD_EX, RegWrite_EX, MemRead_EX, RD_MEM, MemRead_MEM,
        input  PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush, StallCount
    );

    modport slave (
        input  RS_ID, RT_ID, UsesRT_ID, Branch_ID, BranchTaken_ID, Jump_ID,
               RD_EX, RegWrite_EX, MemRead_EX, RD_MEM, MemRead_MEM,
        output PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush, StallCount
    );
endinterface

// File: rtl/hazard_detection_unit.sv
// Decode-stage hazard controller: load-use and branch-operand stalls, branch/jump flush.
// Optional stall counter is built only when HAZARD_PERF_EN is defined.
module hazard_detection_unit (
    input  logic                    Clk,
    input  logic                    Reset_n,
    hazard_detection_unit_if.slave  hz
);
    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_STALL1 = 1'b1
    } state_t;

    state_t r_state;
    state_t w_next_state;
    logic   w_br2;
    logic   w_br1;
    logic   w_lu;
    logic   w_stall;
    logic   w_ex_dep;
    logic   w_mem_dep;

    function automatic logic f_match(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    // NOTE: every variable gets a default at the top so no path leaves one unassigned (no latch).
    always_comb begin
        w_br2        = 1'b0;
        w_br1        = 1'b0;
        w_lu         = 1'b0;
        w_next_state = ST_RUN;
        w_ex_dep     = f_match(hz.RD_EX, hz.RS_ID) || f_match(hz.RD_EX, hz.RT_ID);
        w_mem_dep    = f_match(hz.RD_MEM, hz.RS_ID) || f_match(hz.RD_MEM, hz.RT_ID);

        if (r_state == ST_RUN) begin
            w_lu  = hz.MemRead_EX &&
                    (f_match(hz.RD_EX, hz.RS_ID) || (hz.UsesRT_ID && f_match(hz.RD_EX, hz.RT_ID)));
            w_br2 = hz.Branch_ID && hz.MemRead_EX && w_ex_dep;
            w_br1 = hz.Branch_ID && !w_br2 &&
                    ((hz.RegWrite_EX && w_ex_dep) || (hz.MemRead_MEM && w_mem_dep));
            if (w_br2) begin
                w_next_state = ST_STALL1;
            end
        end

        // Reset forces the pass-through output values regardless of inputs.
        w_stall = Reset_n && ((r_state == ST_STALL1) || w_br2 || w_br1 || w_lu);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    assign hz.PCWrite     = !w_stall;
    assign hz.IFIDWrite   = !w_stall;
    assign hz.IDEX_Bubble = w_stall;
    assign hz.IFID_Flush  = Reset_n && !w_stall &&
                            (hz.Jump_ID || (hz.Branch_ID && hz.BranchTaken_ID));

`ifdef HAZARD_PERF_EN
    logic [15:0] r_stall_count;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_stall_count <= 16'h0000;
        end else if (w_stall && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign hz.StallCount = r_stall_count;
`else
    assign hz.StallCount = 16'h0000;
`endif
endmodule

// File: tb/tb_hazard_detection_unit.sv
// Self-checking bench for hazard_detection_unit: directed literal cases plus a
// randomized run compared every cycle against a stall-budget reference model.
module tb_hazard_detection_unit;
`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic Clk;
    logic Reset_n;
    int   total;
    int   bad;

    hazard_detection_unit_if hif ();

    hazard_detection_unit dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .hz      (hif.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: remaining committed bubbles plus a saturating stall tally.
    int m_pending;
    int m_count;

    function automatic bit rmatch(input logic [4:0] a, input logic [4:0] b);
        return (a != 0) && (a == b);
    endfunction

    // Stall cycles the instruction in ID demands right now (maximum of all requests).
    function automatic int need_now();
        bit dep_ex, dep_mem, br2, br1, lu;
        dep_ex  = rmatch(hif.RD_EX, hif.RS_ID) || rmatch(hif.RD_EX, hif.RT_ID);
        dep_mem = rmatch(hif.RD_MEM, hif.RS_ID) || rmatch(hif.RD_MEM, hif.RT_ID);
        br2 = hif.Branch_ID && hif.MemRead_EX && dep_ex;
        br1 = hif.Branch_ID && ((hif.RegWrite_EX && dep_ex) || (hif.MemRead_MEM && dep_mem));
        lu  = hif.MemRead_EX && (rmatch(hif.RD_EX, hif.RS_ID) ||
                                 (hif.UsesRT_ID && rmatch(hif.RD_EX, hif.RT_ID)));
        if (br2) return 2;
        if (br1 || lu) return 1;
        return 0;
    endfunction

    function automatic bit model_stall();
        return Reset_n && ((m_pending > 0) || (need_now() > 0));
    endfunction

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_pending <= 0;
            m_count   <= 0;
        end else begin
            if (m_pending > 0) m_pending <= m_pending - 1;
            else if (need_now() > 0) m_pending <= need_now() - 1;
            if (PERF && model_stall() && m_count < 65535) m_count <= m_count + 1;
        end
    end

    always @(negedge Clk) begin
        bit es, ef;
        es = model_stall();
        ef = Reset_n && !es && (hif.Jump_ID || (hif.Branch_ID && hif.BranchTaken_ID));
        check("cmp_PCWrite",     32'(hif.PCWrite),     32'(!es));
        check("cmp_IFIDWrite",   32'(hif.IFIDWrite),   32'(!es));
        check("cmp_IDEX_Bubble", 32'(hif.IDEX_Bubble), 32'(es));
        check("cmp_IFID_Flush",  32'(hif.IFID_Flush),  32'(ef));
        check("cmp_StallCount",  32'(hif.StallCount),  32'(m_count));
    end

    task automatic quiet();
        hif.RS_ID = 0; hif.RT_ID = 0; hif.UsesRT_ID = 0; hif.Branch_ID = 0;
        hif.BranchTaken_ID = 0; hif.Jump_ID = 0; hif.RD_EX = 0; hif.RegWrite_EX = 0;
        hif.MemRead_EX = 0; hif.RD_MEM = 0; hif.MemRead_MEM = 0;
    endtask

    // Check one cycle at the falling edge, then advance to just after the next rising edge.
    task automatic cyc(input string name, input bit ep, input bit eb, input bit ef);
        @(negedge Clk);
        check({name, "_PCWrite"},   32'(hif.PCWrite),     32'(ep));
        check({name, "_IFIDWrite"}, 32'(hif.IFIDWrite),   32'(ep));
        check({name, "_Bubble"},    32'(hif.IDEX_Bubble), 32'(eb));
        check({name, "_Flush"},     32'(hif.IFID_Flush),  32'(ef));
        @(posedge Clk);
        #1;
    endtask

    task automatic check_count(input string name, input int exp_perf);
        @(negedge Clk);
        check(name, 32'(hif.StallCount), PERF ? 32'(exp_perf) : 32'h0);
        @(posedge Clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        Reset_n = 1'b0;
        quiet();
        // Hazard and jump patterns during reset must be ignored.
        hif.MemRead_EX = 1; hif.RD_EX = 8; hif.RS_ID = 8; hif.Jump_ID = 1;
        #2;
        check("rst_PCWrite", 32'(hif.PCWrite),     32'd1);
        check("rst_Bubble",  32'(hif.IDEX_Bubble), 32'd0);
        check("rst_Flush",   32'(hif.IFID_Flush),  32'd0);
        check("rst_Count",   32'(hif.StallCount),  32'd0);
        quiet();
        #20 Reset_n = 1'b1;
        @(posedge Clk); #1;

        // Load-use: exactly one bubble.
        hif.MemRead_EX = 1; hif.RD_EX = 8; hif.RS_ID = 8;
        cyc("lu_stall", 0, 1, 0);
        quiet();
        cyc("lu_after", 1, 0, 0);
        // Register 0 never hazards.
        hif.MemRead_EX = 1; hif.RD_EX = 0; hif.RS_ID = 0;
        cyc("lu_zero", 1, 0, 0);
        quiet();
        check_count("cnt_after_lu", 1);

        // Branch after load in EX: two bubbles, then taken-branch flush.
        hif.Branch_ID = 1; hif.BranchTaken_ID = 1; hif.MemRead_EX = 1; hif.RD_EX = 5; hif.RS_ID = 5;
        cyc("br2_s1", 0, 1, 0);
        hif.MemRead_EX = 0; hif.RD_EX = 0; hif.MemRead_MEM = 1; hif.RD_MEM = 5;
        cyc("br2_s2", 0, 1, 0);
        hif.MemRead_MEM = 0; hif.RD_MEM = 0;
        cyc("br2_go", 1, 0, 1);
        quiet();
        check_count("cnt_after_br2", 3);

        // Branch after ALU producer in EX: one bubble, not-taken so no flush.
        hif.Branch_ID = 1; hif.UsesRT_ID = 1; hif.RT_ID = 9; hif.RegWrite_EX = 1; hif.RD_EX = 9;
        cyc("br1ex_s", 0, 1, 0);
        hif.RegWrite_EX = 0; hif.RD_EX = 0;
        cyc("br1ex_go", 1, 0, 0);
        // Branch with load in MEM, EX independent: one bubble.
        hif.RegWrite_EX = 1; hif.RD_EX = 3; hif.MemRead_MEM = 1; hif.RD_MEM = 9;
        cyc("br1mem_s", 0, 1, 0);
        hif.MemRead_MEM = 0; hif.RD_MEM = 0; hif.RegWrite_EX = 0;
        cyc("br1mem_go", 1, 0, 0);
        quiet();
        check_count("cnt_after_br1", 5);

        // Jump with no hazard flushes immediately.
        hif.Jump_ID = 1;
        cyc("jump", 1, 0, 1);
        quiet();

        // Reset asserted during STALL1 aborts the stall at once.
        hif.Branch_ID = 1; hif.MemRead_EX = 1; hif.RD_EX = 5; hif.RT_ID = 5;
        @(posedge Clk); #1;
        quiet();
        #2 Reset_n = 1'b0;
        #1;
        check("rstmid_PCWrite", 32'(hif.PCWrite),     32'd1);
        check("rstmid_Bubble",  32'(hif.IDEX_Bubble), 32'd0);
        check("rstmid_Count",   32'(hif.StallCount),  32'd0);
        #10 Reset_n = 1'b1;
        @(posedge Clk); #1;
        cyc("rstmid_after", 1, 0, 0);

        // Randomized run with small register indices to provoke many matches.
        for (int i = 0; i < 3000; i++) begin
            hif.RS_ID = 5'($urandom_range(0, 3));
            hif.RT_ID = 5'($urandom_range(0, 3));
            hif.RD_EX = 5'($urandom_range(0, 3));
            hif.RD_MEM = 5'($urandom_range(0, 3));
            hif.UsesRT_ID = 1'($urandom);
            hif.Branch_ID = ($urandom_range(0, 2) == 0);
            hif.BranchTaken_ID = 1'($urandom);
            hif.Jump_ID = ($urandom_range(0, 7) == 0);
            hif.RegWrite_EX = 1'($urandom);
            hif.MemRead_EX = ($urandom_range(0, 2) == 0);
            hif.MemRead_MEM = ($urandom_range(0, 2) == 0);
            if (i == 1500) begin
                #3 Reset_n = 1'b0;
                #2 Reset_n = 1'b1;
            end
            @(posedge Clk); #1;
        end

        // Saturation: hold a load-use pattern well past 16 bits of stall cycles.
        quiet();
        hif.MemRead_EX = 1; hif.RD_EX = 7; hif.RS_ID = 7;
        repeat (65540) @(posedge Clk);
        #1;
        cyc("sat_hold", 0, 1, 0);
        check_count("sat_count", 65535);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hazard_detection_unit.md
# hazard_detection_unit

Decode-stage hazard controller for the 5-stage MIPS pipeline, the upstream partner of the EX-stage forwarding logic. It detects the hazards forwarding cannot cover: load-use, and branch-operand dependences, since branches resolve in ID. It stalls PC and IF/ID, injects bubbles into ID/EX, and flushes IF/ID on taken branches and jumps. A small FSM holds multi-cycle stalls so the bubble count is fixed at detection time.

## Interface
No parameters.
- Clk  in  1  rising-edge clock
- Reset_n  in  1  asynchronous active-low reset
- RS_ID  in  5  rs of instruction in ID
- RT_ID  in  5  rt of instruction in ID
- UsesRT_ID  in  1  ID instruction reads rt (R-type, store, branch)
- Branch_ID  in  1  ID instruction is a conditional branch (compares in ID)
- BranchTaken_ID  in  1  branch comparison result in ID
- Jump_ID  in  1  ID instruction is j/jal/jr
- RD_EX  in  5  destination register of instruction in EX
- RegWrite_EX  in  1  EX instruction writes a register
- MemRead_EX  in  1  EX instruction is a load
- RD_MEM  in  5  destination register of instruction in MEM
- MemRead_MEM  in  1  MEM instruction is a load
- PCWrite  out  1  1 = PC may update
- IFIDWrite  out  1  1 = IF/ID may load
- IDEX_Bubble  out  1  1 = zero ID/EX control fields this cycle
- IFID_Flush  out  1  1 = clear IF/ID at next edge
- StallCount  out  16  total stall cycles (see Configuration)

## Operation
- Match(a,b) := a != 0 && a == b. Register 0 never causes a hazard.
- Hazard terms, evaluated only in state RUN:
  - LU: MemRead_EX && (Match(RD_EX,RS_ID) || (UsesRT_ID && Match(RD_EX,RT_ID))).
  - BR2: Branch_ID && MemRead_EX && RD_EX matches RS_ID or RT_ID. Needs 2 stall cycles.
  - BR1: Branch_ID && !BR2 && ((RegWrite_EX && RD_EX matches RS_ID/RT_ID) || (MemRead_MEM && RD_MEM matches RS_ID/RT_ID)). Needs 1 stall cycle.
- Priority: BR2 > BR1 > LU. Stall length is the maximum requested, never the sum.
- FSM states and transitions:
  - RUN -> STALL1 on BR2.
  - RUN -> RUN on BR1 or LU. The stall is the detect cycle itself.
  - STALL1 -> RUN unconditionally.
- Outputs:
  - stall = (RUN && (BR2 || BR1 || LU)) || state == STALL1.
  - PCWrite = IFIDWrite = !stall.
  - IDEX_Bubble = stall.
  - IFID_Flush = !stall && (Jump_ID || (Branch_ID && BranchTaken_ID)).
- Hazard inputs are ignored in STALL1. The committed count is authoritative and no re-detection occurs.
- A branch is never flushed while stalled. Flush fires only in the cycle the branch leaves ID.

## Timing
- All outputs are combinational from state and inputs. They apply at the next rising Clk.
- Load-use costs 1 bubble. Branch after ALU-producer costs 1. Branch after load in EX costs 2. Branch with load in MEM costs 1.
- While Reset_n = 0:
  - state = RUN.
  - PCWrite = 1, IFIDWrite = 1, IDEX_Bubble = 0, IFID_Flush = 0, StallCount = 0.
  - All inputs are ignored.
- Reset asserted mid-stall aborts the stall immediately (async). The first cycle after deassertion evaluates fresh from RUN.
- Deassertion is sampled at a Clk edge. No stall may be inherited across reset.

## Configuration
- HAZARD_PERF_EN defined: StallCount increments by 1 on every Clk edge where stall = 1. It saturates at 16'hFFFF and holds; it does not wrap. It clears only on reset.
- HAZARD_PERF_EN undefined: the counter is not built and StallCount is tied to 16'h0000. Port list is unchanged.

## Test plan
- Load-use: EX lw $8 (MemRead_EX=1, RD_EX=8), ID add rs=8 -> exactly 1 cycle of PCWrite=0, IFIDWrite=0, IDEX_Bubble=1, then PCWrite=1. With rs=0 and RD_EX=0 -> no stall.
- Branch after load: EX lw $5, ID beq rs=5 -> 2 consecutive stall cycles, state RUN->STALL1->RUN. In the third cycle, with BranchTaken_ID=1 -> IFID_Flush=1 for 1 cycle. StallCount +2 with HAZARD_PERF_EN.
- Branch after ALU op: RegWrite_EX=1, RD_EX=9, ID bne rt=9 -> 1 stall cycle. Same with MemRead_MEM=1, RD_MEM=9 and EX independent -> 1 stall cycle.
- Jump with no hazard: Jump_ID=1 -> IFID_Flush=1, PCWrite=1, IDEX_Bubble=0 in the same cycle. Not-taken branch -> IFID_Flush=0.
- Reset mid-stall: trigger BR2, assert Reset_n=0 during STALL1 -> outputs immediately PCWrite=1, IDEX_Bubble=0, StallCount=0. After release with quiet inputs -> no stall.
- Saturation (HAZARD_PERF_EN): hold a load-use pattern for 65 540 cycles -> StallCount stays 16'hFFFF. Without the macro -> StallCount = 0 throughout.
